// File: rtl/si_pkg.sv
// Shared Space Invaders datapath definitions: screen geometry, coordinate
// width, pixel colour struct and the formation FSM encoding.
package si_pkg;

    localparam int SCREEN_W = 640;
    localparam int FLOOR_Y  = 440;
    localparam int COORD_W  = 11;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [2:0] {
        MARCH_R,
        MARCH_L,
        DESC_R,
        DESC_L,
        LANDED,
        CLEARED
    } form_state_t;

endpackage

// File: rtl/formation_extent.sv
// Combinational extents of the live formation: outermost alive columns,
// lowest alive row and an all-dead flag, derived from the alive mask.
module formation_extent #(
    parameter int ROWS  = 3,
    parameter int COLS  = 8,
    parameter int COL_W = (COLS > 1) ? $clog2(COLS) : 1,
    parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic [ROWS*COLS-1:0] alive,
    output logic [COL_W-1:0]     left_col,
    output logic [COL_W-1:0]     right_col,
    output logic [ROW_W-1:0]     low_row,
    output logic                 all_dead
);

    logic [COLS-1:0] col_alive;
    logic [ROWS-1:0] row_alive;

    always_comb begin
        col_alive = '0;
        row_alive = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (alive[r*COLS+c]) begin
                    col_alive[c] = 1'b1;
                    row_alive[r] = 1'b1;
                end
            end
        end
    end

    // Descending scan leaves the smallest index, ascending scans the largest.
    always_comb begin
        left_col  = '0;
        right_col = '0;
        low_row   = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col_alive[c]) left_col = COL_W'(c);
        end
        for (int c = 0; c < COLS; c++) begin
            if (col_alive[c]) right_col = COL_W'(c);
        end
        for (int r = 0; r < ROWS; r++) begin
            if (row_alive[r]) low_row = ROW_W'(r);
        end
    end

    assign all_dead = ~|alive;

endmodule

// File: rtl/enemy_formation.sv
// Enemy formation controller: owns the alive mask, marches the formation,
// detects player-shot kills and renders the formation pixel colour.
module enemy_formation
    import si_pkg::*;
#(
    parameter int          ROWS        = 3,
    parameter int          COLS        = 8,
    parameter int          SPR_W       = 32,
    parameter int          SPR_H       = 24,
    parameter int          PITCH_X     = 64,
    parameter int          PITCH_Y     = 40,
    parameter int          ORIGIN_X    = 40,
    parameter int          ORIGIN_Y    = 40,
    parameter int          STEP_X      = 8,
    parameter int          STEP_Y      = 16,
    parameter int          SCREEN_W    = si_pkg::SCREEN_W,
    parameter int          FLOOR_Y     = si_pkg::FLOOR_Y,
    parameter int          BASE_PERIOD = 200000,
    parameter int          PER_ENEMY   = 40000,
    parameter logic [23:0] ENEMY_RGB   = 24'h00FF00,
    localparam int         N           = ROWS * COLS,
    localparam int         IDX_W       = $clog2(N),
    localparam int         CNT_W       = $clog2(N + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               restart,
    input  logic [9:0]         h_counter,
    input  logic [9:0]         v_counter,
    input  logic               shot_active,
    input  logic [COORD_W-1:0] shot_x,
    input  logic [COORD_W-1:0] shot_y,
    output logic               hit,
    output logic [IDX_W-1:0]   hit_id,
    output logic [N-1:0]       alive,
    output logic [CNT_W-1:0]   alive_count,
    output logic               landed,
    output logic               cleared,
    output logic [7:0]         R,
    output logic [7:0]         G,
    output logic [7:0]         B
);

    localparam int          COL_W       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int          ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int          EXT_W       = COORD_W + 1;
    localparam logic [31:0] PERIOD_FULL = 32'(BASE_PERIOD + N * PER_ENEMY);

    form_state_t        state_q, state_d;
    logic [COORD_W-1:0] off_x_q, off_x_d, off_y_q, off_y_d;
    logic [31:0]        step_cnt_q, step_cnt_d, period_q, period_d;
    logic [N-1:0]       alive_q, alive_d;
    logic               armed_q, armed_d, hit_q, hit_d;
    logic [IDX_W-1:0]   hit_id_q, hit_id_d;
    rgb_t               rgb_q, rgb_d;

    logic [COL_W-1:0]   left_col, right_col;
    logic [ROW_W-1:0]   low_row;
    logic               all_dead;
    logic [CNT_W-1:0]   alive_cnt;
    logic [COORD_W-1:0] cell_x, cell_y, left_x, right_x, low_y;
    logic               shot_in, pix_in, running, step_tick;
    logic               hit_right, hit_left, reach_floor;
    logic [IDX_W-1:0]   shot_idx;
    logic [31:0]        period_next;

    formation_extent #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_extent (
        .alive     (alive_q),
        .left_col  (left_col),
        .right_col (right_col),
        .low_row   (low_row),
        .all_dead  (all_dead)
    );

    // Coordinates wrap modulo 2^COORD_W, so a negative off_x still places boxes correctly.
    function automatic logic in_box(input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by,
                                    input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py);
        logic [EXT_W-1:0] ex, ey;
        ex = {1'b0, bx};
        ey = {1'b0, by};
        return ({1'b0, px} >= ex) && ({1'b0, px} < ex + EXT_W'(SPR_W)) &&
               ({1'b0, py} >= ey) && ({1'b0, py} < ey + EXT_W'(SPR_H));
    endfunction

    always_comb begin
        shot_in  = 1'b0;
        shot_idx = '0;
        pix_in   = 1'b0;
        cell_x   = '0;
        cell_y   = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                cell_x = COORD_W'(ORIGIN_X + c * PITCH_X) + off_x_q;
                cell_y = COORD_W'(ORIGIN_Y + r * PITCH_Y) + off_y_q;
                if (alive_q[r*COLS+c]) begin
                    if (!shot_in && in_box(cell_x, cell_y, shot_x, shot_y)) begin
                        shot_in  = 1'b1;
                        shot_idx = IDX_W'(r * COLS + c);
                    end
                    if (in_box(cell_x, cell_y, {1'b0, h_counter}, {1'b0, v_counter})) pix_in = 1'b1;
                end
            end
        end
    end

    always_comb begin
        alive_cnt = '0;
        for (int i = 0; i < N; i++) alive_cnt = alive_cnt + CNT_W'(alive_q[i]);
    end

    assign left_x      = COORD_W'(ORIGIN_X) + off_x_q + COORD_W'(left_col) * COORD_W'(PITCH_X);
    assign right_x     = COORD_W'(ORIGIN_X) + off_x_q + COORD_W'(right_col) * COORD_W'(PITCH_X);
    assign low_y       = COORD_W'(ORIGIN_Y) + off_y_q + COORD_W'(STEP_Y) + COORD_W'(low_row) * COORD_W'(PITCH_Y);
    assign hit_right   = ({1'b0, right_x} + EXT_W'(SPR_W + STEP_X)) > EXT_W'(SCREEN_W);
    assign hit_left    = left_x < COORD_W'(STEP_X);
    assign reach_floor = ({1'b0, low_y} + EXT_W'(SPR_H)) >= EXT_W'(FLOOR_Y);
    assign period_next = 32'(BASE_PERIOD) + 32'(alive_cnt) * 32'(PER_ENEMY);
    assign step_tick   = (step_cnt_q == period_q - 32'd1);
    assign running     = (state_q != LANDED) && (state_q != CLEARED);

    always_comb begin
        state_d    = state_q;
        off_x_d    = off_x_q;
        off_y_d    = off_y_q;
        step_cnt_d = step_cnt_q;
        period_d   = period_q;
        alive_d    = alive_q;
        armed_d    = armed_q | ~shot_active;
        hit_d      = 1'b0;
        hit_id_d   = hit_id_q;
        rgb_d      = pix_in ? rgb_t'(ENEMY_RGB) : '0;
        if (running) begin
            if (all_dead) begin
                state_d = CLEARED;
            end else begin
                if (shot_active && armed_q && shot_in) begin
                    alive_d[shot_idx] = 1'b0;
                    hit_d             = 1'b1;
                    hit_id_d          = shot_idx;
                    armed_d           = 1'b0;
                end
                // Step decisions use the pre-kill extents even if a kill lands this cycle.
                if (step_tick) begin
                    step_cnt_d = '0;
                    period_d   = period_next;
                    case (state_q)
                        MARCH_R: begin
                            if (hit_right) state_d = DESC_R;
                            else           off_x_d = off_x_q + COORD_W'(STEP_X);
                        end
                        MARCH_L: begin
                            if (hit_left) state_d = DESC_L;
                            else          off_x_d = off_x_q - COORD_W'(STEP_X);
                        end
                        DESC_R, DESC_L: begin
                            off_y_d = off_y_q + COORD_W'(STEP_Y);
                            if (reach_floor)           state_d = LANDED;
                            else if (state_q == DESC_R) state_d = MARCH_L;
                            else                       state_d = MARCH_R;
                        end
                        default: state_d = state_q;
                    endcase
                end else begin
                    step_cnt_d = step_cnt_q + 32'd1;
                end
            end
        end
        if (restart) begin
            state_d    = MARCH_R;
            off_x_d    = '0;
            off_y_d    = '0;
            step_cnt_d = '0;
            period_d   = PERIOD_FULL;
            alive_d    = '1;
            armed_d    = 1'b1;
            hit_d      = 1'b0;
            hit_id_d   = '0;
            rgb_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= MARCH_R;
            off_x_q    <= '0;
            off_y_q    <= '0;
            step_cnt_q <= '0;
            period_q   <= PERIOD_FULL;
            alive_q    <= '1;
            armed_q    <= 1'b1;
            hit_q      <= 1'b0;
            hit_id_q   <= '0;
            rgb_q      <= '0;
        end else begin
            state_q    <= state_d;
            off_x_q    <= off_x_d;
            off_y_q    <= off_y_d;
            step_cnt_q <= step_cnt_d;
            period_q   <= period_d;
            alive_q    <= alive_d;
            armed_q    <= armed_d;
            hit_q      <= hit_d;
            hit_id_q   <= hit_id_d;
            rgb_q      <= rgb_d;
        end
    end

    assign hit         = hit_q;
    assign hit_id      = hit_id_q;
    assign alive       = alive_q;
    assign alive_count = alive_cnt;
    assign landed      = (state_q == LANDED);
    assign cleared     = (state_q == CLEARED);
    assign R           = rgb_q.r;
    assign G           = rgb_q.g;
    assign B           = rgb_q.b;

endmodule
